// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants, reverse decode helper and output-stage state type.
// Segment order is bit0=a ... bit6=g, active-high.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    StEmpty,
    StFull
  } out_state_e;

  // Returns {invalid, blank, code[3:0]}; code is 0 for blank or invalid patterns.
  function automatic logic [5:0] seg7_to_hex(input logic [6:0] pattern);
    logic [5:0] res;
    res = 6'b10_0000;
    case (pattern)
      SEG_0:     res = 6'h00;
      SEG_1:     res = 6'h01;
      SEG_2:     res = 6'h02;
      SEG_3:     res = 6'h03;
      SEG_4:     res = 6'h04;
      SEG_5:     res = 6'h05;
      SEG_6:     res = 6'h06;
      SEG_7:     res = 6'h07;
      SEG_8:     res = 6'h08;
      SEG_9:     res = 6'h09;
      SEG_A:     res = 6'h0A;
      SEG_B:     res = 6'h0B;
      SEG_C:     res = 6'h0C;
      SEG_D:     res = 6'h0D;
      SEG_E:     res = 6'h0E;
      SEG_F:     res = 6'h0F;
      SEG_BLANK: res = 6'b01_0000;
      default:   res = 6'b10_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_sync_filter.sv
// Two-flop synchronizer plus stability filter for the segment bus.
// accept_o pulses once per settled candidate pattern.
module seg7_sync_filter
  import seg7_pkg::*;
#(
  parameter int unsigned StableCycles = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_i,
  output logic [6:0] cand_o,
  output logic       accept_o
);

  localparam int unsigned CntW = $clog2(StableCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StableCycles);

  logic [6:0]      s1_q, s2_q;
  logic [6:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fired_q, fired_d;
  logic            accept;

  // fired_q marks that this candidate already produced its accept, since cnt saturates.
  assign accept = (cnt_q == CntMax) && !fired_q;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    fired_d = fired_q;
    if (s2_q != cand_q) begin
      cand_d  = s2_q;
      cnt_d   = CntW'(1);
      fired_d = 1'b0;
    end else begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (accept) begin
        fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 7'h00;
      s2_q    <= 7'h00;
      cand_q  <= 7'h00;
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      s1_q    <= seg_i;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  assign cand_o   = cand_q;
  assign accept_o = accept;

endmodule

// File: rtl/seg7_reader.sv
// 7-segment pattern reader: filters the async segment bus, decodes new stable
// patterns to hex and presents them through a single-entry valid/ready register.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] code,
  output logic       blank,
  output logic       invalid,
  output logic       overrun
);

  logic [6:0] cand;
  logic       accept;
  logic       evt;
  logic [5:0] dec;

  out_state_e state_q, state_d;
  logic [6:0] last_q, last_d;
  logic [3:0] code_q, code_d;
  logic       blank_q, blank_d;
  logic       invalid_q, invalid_d;
  logic       overrun_q, overrun_d;

  seg7_sync_filter #(
    .StableCycles(STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_i   (seg_in),
    .cand_o  (cand),
    .accept_o(accept)
  );

  // Re-settling on the previously accepted pattern is not a new event.
  assign evt = accept && (cand != last_q);
  assign dec = seg7_to_hex(cand);

  always_comb begin
    state_d   = state_q;
    last_d    = accept ? cand : last_q;
    code_d    = code_q;
    blank_d   = blank_q;
    invalid_d = invalid_q;
    overrun_d = overrun_q;
    if (evt) begin
      code_d    = dec[3:0];
      blank_d   = dec[4];
      invalid_d = dec[5];
    end
    unique case (state_q)
      StEmpty: begin
        if (evt) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (evt && !out_ready) begin
          overrun_d = 1'b1;
        end else if (!evt && out_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      last_q    <= 7'h00;
      code_q    <= 4'h0;
      blank_q   <= 1'b0;
      invalid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      code_q    <= code_d;
      blank_q   <= blank_d;
      invalid_q <= invalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign code      = code_q;
  assign blank     = blank_q;
  assign invalid   = invalid_q;
  assign overrun   = overrun_q;

endmodule
